ice40_spi_wb_xfer: RTL and testbench

//  Wishbone master that drives the SB_SPI wrapper (4-bit wb_addr, 8-bit data) as a byte-stream SPI master.

---
 rtl/ice40_spi_pkg.sv | 32 +++
 rtl/ice40_spi_wb_xfer_bus.sv | 43 ++++
 rtl/ice40_spi_wb_xfer.sv | 186 ++++++++++++++++++
 tb/tb_ice40_spi_wb_xfer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ice40_spi_pkg.sv
// Shared definitions for the SB_SPI wishbone byte-stream master: register map,
// status bit positions, init values and the controller state encoding.
package ice40_spi_pkg;

  localparam logic [3:0] REG_CR1  = 4'h9;
  localparam logic [3:0] REG_CR2  = 4'hA;
  localparam logic [3:0] REG_BR   = 4'hB;
  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_RXDR = 4'hE;
  localparam logic [3:0] REG_CSR  = 4'hF;

  localparam int SR_TIP  = 7;
  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;

  localparam logic [7:0] CR1_INIT = 8'h80;
  localparam logic [7:0] CR2_INIT = 8'hC0;
  localparam logic [7:0] CSR_IDLE = 8'h0F;

  typedef enum logic [3:0] {
    ST_INIT0, ST_INIT1, ST_INIT2, ST_INIT3,
    ST_IDLE, ST_CSON, ST_WTRDY, ST_TXW,
    ST_WRRDY, ST_RXR, ST_WTIP, ST_CSOFF
  } state_t;

  // Active-low chip-select pattern with only the selected line driven low.
  function automatic logic [7:0] csr_select(input logic [1:0] idx);
    return CSR_IDLE & ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/ice40_spi_wb_xfer_bus.sv
// Single-access wishbone engine: launches one access per request, holds the
// bus stable until ack, and signals completion in the ack cycle.
module ice40_spi_wb_xfer_bus (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cyc,
  output logic [3:0] bus_addr,
  output logic       bus_we,
  output logic [7:0] bus_wdata,
  input  logic       ack,
  input  logic [7:0] bus_rdata
);

  // A new access is only launched from a cycle with cyc low, so the ack
  // cycle is always followed by at least one idle cycle on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 1'b0;
      bus_addr  <= 4'h0;
      bus_we    <= 1'b0;
      bus_wdata <= 8'h00;
    end else if (!cyc) begin
      if (req) begin
        cyc       <= 1'b1;
        bus_addr  <= addr;
        bus_we    <= we;
        bus_wdata <= wdata;
      end
    end else if (ack) begin
      cyc <= 1'b0;
    end
  end

  assign done  = cyc & ack;
  assign rdata = bus_rdata;

endmodule

// File: rtl/ice40_spi_wb_xfer.sv
// Byte-stream SPI master on top of the SB_SPI wishbone wrapper: configures the
// hard IP after reset, then runs one CS/TX/RX sequence per accepted byte.
module ice40_spi_wb_xfer
  import ice40_spi_pkg::*;
#(
  parameter int N_CS    = 1,
  parameter int CLK_DIV = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_data,
  input  logic [1:0]  tx_cs,
  input  logic        tx_last,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_wdata,
  input  logic [31:0] wb_rdata,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic        wb_ack
);

  localparam logic [1:0] CS_MAX   = 2'(N_CS - 1);
  localparam logic [9:0] POLL_MAX = 10'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       req, acc_we, done, timeout, accept;
  logic       cs_act, resume, last_q, poll_last;
  logic [3:0] acc_addr;
  logic [7:0] acc_wdata, rdata, data_q, bus_wdata;
  logic [1:0] cs_q, cs_idx, tx_cs_eff;
  logic [9:0] poll_cnt;
  logic       rdata_unused;

  ice40_spi_wb_xfer_bus u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (acc_addr),
    .we        (acc_we),
    .wdata     (acc_wdata),
    .done      (done),
    .rdata     (rdata),
    .cyc       (wb_cyc),
    .bus_addr  (wb_addr),
    .bus_we    (wb_we),
    .bus_wdata (bus_wdata),
    .ack       (wb_ack),
    .bus_rdata (wb_rdata[7:0])
  );

  assign wb_wdata     = {24'h0, bus_wdata};
  assign rdata_unused = ^wb_rdata[31:8];

  // Out-of-range indices are clamped to the highest implemented select.
  assign tx_cs_eff = (tx_cs > CS_MAX) ? CS_MAX : tx_cs;
  assign tx_ready  = (state == ST_IDLE) && !rx_valid;
  assign accept    = tx_valid && tx_ready;
  assign poll_last = (poll_cnt == POLL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b1;
    acc_addr  = REG_SR;
    acc_we    = 1'b0;
    acc_wdata = 8'h00;
    timeout   = 1'b0;
    case (state)
      ST_INIT0: begin
        acc_addr = REG_CR1; acc_we = 1'b1; acc_wdata = CR1_INIT;
        if (done) state_nxt = ST_INIT1;
      end
      ST_INIT1: begin
        acc_addr = REG_CR2; acc_we = 1'b1; acc_wdata = CR2_INIT;
        if (done) state_nxt = ST_INIT2;
      end
      ST_INIT2: begin
        acc_addr = REG_BR; acc_we = 1'b1; acc_wdata = 8'(CLK_DIV);
        if (done) state_nxt = ST_INIT3;
      end
      ST_INIT3: begin
        acc_addr = REG_CSR; acc_we = 1'b1; acc_wdata = CSR_IDLE;
        if (done) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req = 1'b0;
        if (accept) begin
          if (!cs_act)                  state_nxt = ST_CSON;
          else if (cs_idx != tx_cs_eff) state_nxt = ST_CSOFF;
          else                          state_nxt = ST_WTRDY;
        end
      end
      ST_CSON: begin
        acc_addr = REG_CSR; acc_we = 1'b1; acc_wdata = csr_select(cs_q);
        if (done) state_nxt = ST_WTRDY;
      end
      ST_WTRDY: begin
        if (done) begin
          if (rdata[SR_TRDY]) state_nxt = ST_TXW;
          else if (poll_last) begin timeout = 1'b1; state_nxt = ST_CSOFF; end
        end
      end
      ST_TXW: begin
        acc_addr = REG_TXDR; acc_we = 1'b1; acc_wdata = data_q;
        if (done) state_nxt = ST_WRRDY;
      end
      ST_WRRDY: begin
        if (done) begin
          if (rdata[SR_RRDY]) state_nxt = ST_RXR;
          else if (poll_last) begin timeout = 1'b1; state_nxt = ST_CSOFF; end
        end
      end
      ST_RXR: begin
        acc_addr = REG_RXDR;
        if (done) state_nxt = last_q ? ST_WTIP : ST_IDLE;
      end
      ST_WTIP: begin
        if (done) begin
          if (!rdata[SR_TIP]) state_nxt = ST_CSOFF;
          else if (poll_last) begin timeout = 1'b1; state_nxt = ST_CSOFF; end
        end
      end
      ST_CSOFF: begin
        acc_addr = REG_CSR; acc_we = 1'b1; acc_wdata = CSR_IDLE;
        if (done) state_nxt = resume ? ST_CSON : ST_IDLE;
      end
      default: state_nxt = ST_INIT0;
    endcase
  end

  // resume marks a CSOFF that is only a detour on the way to a new select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= 8'h00;
      cs_q     <= 2'd0;
      last_q   <= 1'b0;
      resume   <= 1'b0;
      cs_act   <= 1'b0;
      cs_idx   <= 2'd0;
      poll_cnt <= 10'd0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= tx_data;
        cs_q   <= tx_cs_eff;
        last_q <= tx_last;
        resume <= cs_act && (cs_idx != tx_cs_eff);
      end
      if (state_nxt != state) poll_cnt <= 10'd0;
      else if (done)          poll_cnt <= poll_cnt + 10'd1;
      if (state == ST_CSON && done) begin
        cs_act <= 1'b1;
        cs_idx <= cs_q;
      end
      if (state == ST_CSOFF && done) begin
        cs_act <= 1'b0;
        resume <= 1'b0;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state == ST_RXR && done) begin
        rx_data  <= rdata;
        rx_valid <= 1'b1;
      end
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      busy <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ice40_spi_wb_xfer.sv
// Directed plus randomized bench: wishbone wrapper model with variable ack delay,
// scripted SR/RXDR, and a transaction-level model of the expected access stream.
module tb_ice40_spi_wb_xfer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic [1:0]  tx_cs;
  logic        tx_last, tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, busy, err, err_clr;
  logic [3:0]  wb_addr;
  logic [31:0] wb_wdata, wb_rdata;
  logic        wb_we, wb_cyc, wb_ack;

  ice40_spi_wb_xfer #(.N_CS(2), .CLK_DIV(2), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_cs(tx_cs), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .err(err), .err_clr(err_clr), .wb_addr(wb_addr),
    .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  // Wrapper model
  int         ack_set = 0;
  bit         ack_rand = 1'b0;
  int         ack_dly_r = 0;
  int         wait_cnt = 0;
  int         cyc_n = 0;
  logic [7:0] sr_val;
  logic [7:0] rx_script [64];
  logic [5:0] rx_idx = 6'd0;
  int         cur_dly;

  assign cur_dly  = ack_rand ? ack_dly_r : ack_set;
  assign wb_ack   = wb_cyc && (wait_cnt >= cur_dly);
  assign wb_rdata = {24'hA5C35A, (wb_addr == 4'hC) ? sr_val :
                                 (wb_addr == 4'hE) ? rx_script[rx_idx] : 8'h00};

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wb_cyc && !wb_ack) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
    if (wb_cyc && wb_ack) begin
      ack_dly_r <= int'($urandom_range(0, 3));
      if (!wb_we && wb_addr == 4'hE) rx_idx <= rx_idx + 6'd1;
    end
  end

  function automatic logic [31:0] enc(input bit we, input logic [3:0] a, input logic [7:0] d);
    return {19'h0, we, a, we ? d : 8'h00};
  endfunction

  // Bus / rx monitor
  logic [31:0] acc_log [8192];
  int          acc_n = 0;
  logic [7:0]  rx_log [256];
  int          rx_n = 0;
  int          stab_bad = 0, gap_bad = 0, hi_bad = 0;
  bit          prev_pend = 1'b0, prev_ack = 1'b0;
  logic [36:0] prev_sig = '0;

  always @(negedge clk) begin
    if (wb_cyc && wb_ack) begin
      acc_log[acc_n] <= enc(wb_we, wb_addr, wb_wdata[7:0]);
      acc_n <= acc_n + 1;
    end
    if (rx_valid && rx_ready) begin
      rx_log[rx_n[7:0]] <= rx_data;
      rx_n <= rx_n + 1;
    end
    if (wb_cyc && prev_pend && {wb_addr, wb_we, wb_wdata} != prev_sig) stab_bad <= stab_bad + 1;
    if (wb_cyc && prev_ack) gap_bad <= gap_bad + 1;
    if (wb_cyc && wb_wdata[31:8] != 24'h0) hi_bad <= hi_bad + 1;
    prev_pend <= wb_cyc && !wb_ack;
    prev_ack  <= wb_cyc && wb_ack;
    prev_sig  <= {wb_addr, wb_we, wb_wdata};
  end

  // Checking and reference model
  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  exp_rx [$];
  bit          m_act = 1'b0;
  logic [1:0]  m_idx = 2'd0;
  logic [5:0]  m_rxi = 6'd0;
  int          t_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input logic [1:0] cs, input bit last);
    logic [7:0] sel;
    if (m_act && m_idx != cs) begin
      exp_q.push_back(enc(1'b1, 4'hF, 8'h0F));
      m_act = 1'b0;
    end
    if (!m_act) begin
      sel = 8'h0F;
      sel[cs] = 1'b0;
      exp_q.push_back(enc(1'b1, 4'hF, sel));
      m_act = 1'b1;
      m_idx = cs;
    end
    exp_q.push_back(enc(1'b0, 4'hC, 8'h00));
    exp_q.push_back(enc(1'b1, 4'hD, d));
    exp_q.push_back(enc(1'b0, 4'hC, 8'h00));
    exp_q.push_back(enc(1'b0, 4'hE, 8'h00));
    exp_rx.push_back(rx_script[m_rxi]);
    m_rxi = m_rxi + 6'd1;
    if (last) begin
      exp_q.push_back(enc(1'b0, 4'hC, 8'h00));
      exp_q.push_back(enc(1'b1, 4'hF, 8'h0F));
      m_act = 1'b0;
    end
  endtask

  task automatic push_init();
    exp_q.push_back(enc(1'b1, 4'h9, 8'h80));
    exp_q.push_back(enc(1'b1, 4'hA, 8'hC0));
    exp_q.push_back(enc(1'b1, 4'hB, 8'h02));
    exp_q.push_back(enc(1'b1, 4'hF, 8'h0F));
  endtask

  task automatic cmp_acc(input string tag, input int base);
    chk({tag, "_count"}, 32'(acc_n - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < acc_n) chk(tag, acc_log[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic cmp_rx(input string tag, input int rbase);
    chk({tag, "_count"}, 32'(rx_n - rbase), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size(); i++)
      if (rbase + i < rx_n) chk(tag, {24'h0, rx_log[8'(rbase + i)]}, {24'h0, exp_rx[i]});
    exp_rx.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [1:0] cs, input bit last);
    int n;
    n = 0;
    tx_data = d; tx_cs = cs; tx_last = last; tx_valid = 1'b1;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("tx_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    t_acc = cyc_n;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || wb_cyc || rx_valid) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < bound), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, rbase, n, blocked;
    logic [7:0] d;
    logic [1:0] c;
    bit l;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_cs = 2'd0; tx_last = 1'b0;
    rx_ready = 1'b1; err_clr = 1'b0; sr_val = 8'h18;
    for (int i = 0; i < 64; i++) rx_script[i] = 8'($urandom);
    repeat (3) @(negedge clk);

    // 1: reset values, then the init write sequence
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    base = acc_n;
    rst_n = 1'b1;
    push_init();
    wait_ready("init_ready");
    cmp_acc("init_seq", base);

    // 2: single byte with CS open/close
    base = acc_n; rbase = rx_n;
    rx_script[m_rxi] = 8'h3C;
    model_byte(8'hA5, 2'd0, 1'b1);
    send_byte(8'hA5, 2'd0, 1'b1);
    wait_idle("t2_idle", 200);
    cmp_acc("t2_acc", base);
    cmp_rx("t2_rx", rbase);

    // 3: three bytes on cs=1, latency of a byte with CS already active
    base = acc_n; rbase = rx_n;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      model_byte(d, 2'd1, i == 2);
      send_byte(d, 2'd1, i == 2);
      if (i == 1) begin
        n = 0;
        while (!rx_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("latency", 32'(cyc_n - t_acc), 32'd8);
      end
    end
    wait_idle("t3_idle", 300);
    cmp_acc("t3_acc", base);
    cmp_rx("t3_rx", rbase);

    // 4: rx back-pressure blocks the next byte
    base = acc_n; rbase = rx_n;
    ack_set = 1;
    rx_ready = 1'b0;
    d = 8'($urandom);
    model_byte(d, 2'd0, 1'b0);
    send_byte(d, 2'd0, 1'b0);
    n = 0;
    while (!rx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_rx_valid", 32'(rx_valid), 32'd1);
    chk("t4_rx_data", {24'h0, rx_data}, {24'h0, exp_rx[0]});
    d = 8'($urandom);
    tx_data = d; tx_cs = 2'd0; tx_last = 1'b1; tx_valid = 1'b1;
    blocked = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_ready || wb_cyc) blocked++;
    end
    chk("t4_blocked", 32'(blocked), 32'd0);
    chk("t4_rx_held", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    model_byte(d, 2'd0, 1'b1);
    send_byte(d, 2'd0, 1'b1);
    wait_idle("t4_idle", 300);
    cmp_acc("t4_acc", base);
    cmp_rx("t4_rx", rbase);

    // 5: TRDY never set -> poll timeout, byte dropped, err sticky until err_clr
    base = acc_n; rbase = rx_n;
    ack_set = 0;
    sr_val = 8'h08;
    exp_q.push_back(enc(1'b1, 4'hF, 8'h0E));
    for (int i = 0; i < 1023; i++) exp_q.push_back(enc(1'b0, 4'hC, 8'h00));
    exp_q.push_back(enc(1'b1, 4'hF, 8'h0F));
    send_byte(8'h5A, 2'd0, 1'b0);
    wait_idle("t5_idle", 5000);
    cmp_acc("t5_acc", base);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_no_rx", 32'(rx_n - rbase), 32'd0);
    chk("t5_ready", 32'(tx_ready), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_err_clr", 32'(err), 32'd0);
    sr_val = 8'h18;

    // 6: async reset during a stalled access, then full re-init
    ack_set = 3;
    send_byte(8'h77, 2'd1, 1'b1);
    n = 0;
    while (!wb_cyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_cyc_seen", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cyc_async", 32'(wb_cyc), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tx_ready", 32'(tx_ready), 32'd0);
    repeat (2) @(negedge clk);
    base = acc_n;
    rst_n = 1'b1;
    push_init();
    wait_ready("t6_ready");
    cmp_acc("t6_reinit", base);

    // 7: random stream with random ack delays and CS changes
    base = acc_n; rbase = rx_n;
    ack_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      c = 2'($urandom_range(0, 1));
      l = ($urandom_range(0, 2) == 0) || (i == 23);
      model_byte(d, c, l);
      send_byte(d, c, l);
    end
    wait_idle("t7_idle", 500);
    cmp_acc("t7_acc", base);
    cmp_rx("t7_rx", rbase);

    chk("bus_stable", 32'(stab_bad), 32'd0);
    chk("bus_gap", 32'(gap_bad), 32'd0);
    chk("wdata_high", 32'(hi_bad), 32'd0);
    chk("final_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
